// File: rtl/hazard_scheduler.sv
`default_nettype none
// ==========================================================================
// hazard_scheduler : RV32I 5-stage hazard, forwarding and mem-freeze control
// Revision 1.0
// ==========================================================================
module hazard_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_ID,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  rd_ID,
  input  logic        rs1use,
  input  logic        rs2use,
  input  logic [1:0]  hazard_optype,
  input  logic        RegWrite_ID,
  input  logic        DatatoReg_ID,
  input  logic        MIO_ID,
  input  logic        Branch_ID,
  input  logic        mem_ready,
  output logic        PC_EN_IF,
  output logic        reg_FD_EN,
  output logic        reg_DE_EN,
  output logic        reg_EM_EN,
  output logic        reg_MW_EN,
  output logic        reg_FD_flush,
  output logic        reg_DE_flush,
  output logic [1:0]  forward_ctrl_A,
  output logic [1:0]  forward_ctrl_B,
  output logic        fwd_store_M,
  output logic        mem_req,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0]  OPT_STORE = 2'b10;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // W is not stored: the register file's write-before-read already covers it.
  logic       e_valid, e_wr, e_ld, e_mio;
  logic [4:0] e_rd;
  logic       m_valid, m_wr, m_ld, m_mio;
  logic [4:0] m_rd;
  logic       pend_e;

  logic hit_e1, hit_e2, hit_m1, hit_m2;
  logic lu_rs1, lu_rs2, store_exc, lu, mf, branch;

  assign hit_e1 = rs1use & e_valid & e_wr & (e_rd == rs1_ID);
  assign hit_e2 = rs2use & e_valid & e_wr & (e_rd == rs2_ID);
  assign hit_m1 = rs1use & m_valid & m_wr & (m_rd == rs1_ID);
  assign hit_m2 = rs2use & m_valid & m_wr & (m_rd == rs2_ID);

  assign lu_rs1    = hit_e1 & e_ld;
  assign lu_rs2    = hit_e2 & e_ld;
  // A store whose only dependency is its data operand can pick the load
  // result up in MEM from WB instead of stalling.
  assign store_exc = (hazard_optype == OPT_STORE) & lu_rs2 & ~lu_rs1;
  assign lu        = valid_ID & (lu_rs1 | lu_rs2) & ~store_exc;

  assign mem_req = m_valid & m_mio;
  assign mf      = mem_req & ~mem_ready;
  assign branch  = Branch_ID & valid_ID & ~mf & ~lu;

  always_comb begin
    forward_ctrl_A = 2'b00;
    forward_ctrl_B = 2'b00;
    if (hit_e1 && !e_ld)  forward_ctrl_A = 2'b01;
    else if (hit_m1)      forward_ctrl_A = m_ld ? 2'b11 : 2'b10;
    if (hit_e2 && !e_ld)  forward_ctrl_B = 2'b01;
    else if (hit_m2)      forward_ctrl_B = m_ld ? 2'b11 : 2'b10;
  end

  assign PC_EN_IF     = rst & ~mf & ~lu;
  assign reg_FD_EN    = rst & ~mf & ~lu;
  assign reg_DE_EN    = rst & ~mf;
  assign reg_EM_EN    = rst & ~mf;
  assign reg_MW_EN    = rst & ~mf;
  assign reg_FD_flush = rst & branch;
  assign reg_DE_flush = rst & ~mf & lu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid      <= 1'b0;
      e_rd         <= 5'd0;
      e_wr         <= 1'b0;
      e_ld         <= 1'b0;
      e_mio        <= 1'b0;
      m_valid      <= 1'b0;
      m_rd         <= 5'd0;
      m_wr         <= 1'b0;
      m_ld         <= 1'b0;
      m_mio        <= 1'b0;
      pend_e       <= 1'b0;
      fwd_store_M  <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      if ((mf || lu) && stall_cycles != STALL_MAX)
        stall_cycles <= stall_cycles + 16'd1;
      if (!mf) begin
        m_valid     <= e_valid;
        m_rd        <= e_rd;
        m_wr        <= e_wr;
        m_ld        <= e_ld;
        m_mio       <= e_mio;
        fwd_store_M <= pend_e;
        if (lu) begin
          e_valid <= 1'b0;
          e_wr    <= 1'b0;
          e_ld    <= 1'b0;
          e_mio   <= 1'b0;
          pend_e  <= 1'b0;
        end else begin
          e_valid <= valid_ID;
          e_rd    <= rd_ID;
          e_wr    <= RegWrite_ID & (rd_ID != 5'd0);
          e_ld    <= DatatoReg_ID;
          e_mio   <= MIO_ID;
          pend_e  <= valid_ID & store_exc;
        end
      end
    end
  end

endmodule
`default_nettype wire
